// File: rtl/i2c_pkg.sv
// Shared I2C constants and receive-FSM encoding for the slave receive path.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_t;

  // An addressed write is in progress from the address ACK until stop or re-start.
  function automatic logic state_is_busy(input state_t s);
    return (s == ST_ADDR_ACK) || (s == ST_DATA) || (s == ST_DATA_ACK);
  endfunction

endpackage

// File: rtl/i2c_sync.sv
// Multi-stage synchronizer for one asynchronous bus-side level.
module i2c_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  // Flops reset to the idle-bus level so release of rst creates no false edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C write-only slave receiver: matches a 7-bit address, ACKs and delivers data bytes.
// Handshake: rx_valid is a one-clk pulse with rx_data; the byte is ACKed only if rx_ready was 1.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR    = 7'h42,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              sda_oe,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              overrun,
  output state_t            o_dbg_state
);

  logic w_scl;
  logic w_sda;
  logic w_start_lvl;
  logic w_stop_lvl;

  i2c_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scl (
    .clk(clk), .rst(rst), .i_async(scl_i), .o_sync(w_scl)
  );
  i2c_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sda (
    .clk(clk), .rst(rst), .i_async(sda_i), .o_sync(w_sda)
  );
  i2c_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_start (
    .clk(clk), .rst(rst), .i_async(start_i), .o_sync(w_start_lvl)
  );
  i2c_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_stop (
    .clk(clk), .rst(rst), .i_async(stop_i), .o_sync(w_stop_lvl)
  );

  logic r_scl_d;
  logic r_start_d;
  logic r_stop_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_d   <= 1'b1;
      r_start_d <= 1'b1;
      r_stop_d  <= 1'b1;
    end else begin
      r_scl_d   <= w_scl;
      r_start_d <= w_start_lvl;
      r_stop_d  <= w_stop_lvl;
    end
  end

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_start_lvl & ~r_start_d;
  assign w_stop     = w_stop_lvl & ~r_stop_d;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              r_full;
  logic [BYTE_W-1:0] r_shift;
  logic              r_sda_oe;
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_overrun;

  state_t            w_state_nxt;
  logic [2:0]        w_cnt_nxt;
  logic              w_full_nxt;
  logic [BYTE_W-1:0] w_shift_nxt;
  logic              w_sda_oe_nxt;
  logic              w_rx_load;
  logic              w_ovr_set;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_full_nxt   = r_full;
    w_shift_nxt  = r_shift;
    w_sda_oe_nxt = r_sda_oe;
    w_rx_load    = 1'b0;
    w_ovr_set    = 1'b0;

    // Stop beats a simultaneous start; both abort whatever byte is in flight.
    if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_sda_oe_nxt = 1'b0;
      w_cnt_nxt    = 3'd0;
      w_full_nxt   = 1'b0;
      w_shift_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_sda_oe_nxt = 1'b0;
        end
        ST_ADDR, ST_DATA: begin
          if (w_scl_rise && !r_full) begin
            w_shift_nxt = {r_shift[BYTE_W-2:0], w_sda};
            w_cnt_nxt   = r_cnt + 3'd1;
            w_full_nxt  = (r_cnt == 3'd7);
          end else if (w_scl_fall && r_full) begin
            if (r_state == ST_ADDR) begin
              if (r_shift[BYTE_W-1:1] == DEV_ADDR && !r_shift[0]) begin
                w_state_nxt  = ST_ADDR_ACK;
                w_sda_oe_nxt = 1'b1;
              end else begin
                w_state_nxt  = ST_IGNORE;
                w_sda_oe_nxt = 1'b0;
              end
            end else begin
              w_state_nxt = ST_DATA_ACK;
              if (rx_ready) begin
                w_rx_load    = 1'b1;
                w_sda_oe_nxt = 1'b1;
              end else begin
                w_ovr_set    = 1'b1;
                w_sda_oe_nxt = 1'b0;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt  = ST_DATA;
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 3'd0;
            w_full_nxt   = 1'b0;
          end
        end
        ST_IGNORE: begin
          w_sda_oe_nxt = 1'b0;
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_full     <= 1'b0;
      r_shift    <= '0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_full     <= w_full_nxt;
      r_shift    <= w_shift_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rx_valid <= w_rx_load;
      if (w_rx_load) begin
        r_rx_data <= r_shift;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign sda_oe      = r_sda_oe;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign overrun     = r_overrun;
  assign busy        = state_is_busy(r_state);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-level I2C master, transaction-level reference model, rx scoreboard.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  logic       clk;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       sda_w;
  logic       start_i;
  logic       stop_i;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       overrun;
  state_t     dbg_state;

  // Open-drain wire: the slave's ACK pulls the line low.
  assign sda_w = m_sda & ~sda_oe;

  i2c_slave_rx #(.DEV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_w),
    .start_i(start_i), .stop_i(stop_i), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic       exp_ovr;
  logic [7:0] exp_last;
  logic       prev_valid;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every rx_valid pulse pops one expected byte.
  initial prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rx_valid", 32'd1, 32'd0);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (prev_valid) check("rx_valid_back_to_back", 32'd1, 32'd0);
      end
      prev_valid = rx_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic q();
    repeat (4) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    q();
    m_scl = 1'b1;
    q(); q();
    m_scl = 1'b0;
    q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

  task automatic ack_slot(input logic exp_ack, input logic exp_busy, input string name);
    m_sda = 1'b1;
    q();
    m_scl = 1'b1;
    q();
    @(negedge clk);
    check({name, "_sda_oe"}, {31'd0, sda_oe}, {31'd0, exp_ack});
    check({name, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    q();
    m_scl = 1'b0;
    q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    q();
    m_scl = 1'b1;
    q();
    m_sda   = 1'b0;
    start_i = 1'b1;
    q();
    m_scl   = 1'b0;
    start_i = 1'b0;
    q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    q();
    m_scl = 1'b1;
    q();
    m_sda  = 1'b1;
    stop_i = 1'b1;
    q();
    stop_i = 1'b0;
    q();
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rst      = 1'b0;
    exp_ovr  = 1'b0;
    exp_last = 8'h00;
    exp_q.delete();
  endtask

  // ---------------- reference model + transaction ----------------
  logic [7:0] tx_data[8];
  logic       tx_ready[8];

  task automatic run_txn(input logic [6:0] addr, input logic rw, input int len, input string name);
    logic addressed;
    logic ack;
    addressed = (addr == 7'h42) && !rw;
    i2c_start();
    send_bits({addr, rw}, 8);
    ack_slot(addressed, addressed, {name, "_aack"});
    @(negedge clk);
    check({name, "_state_after_addr"}, {29'd0, dbg_state},
          addressed ? {29'd0, ST_DATA} : {29'd0, ST_IGNORE});
    for (int k = 0; k < len; k++) begin
      rx_ready = tx_ready[k];
      ack = addressed && tx_ready[k];
      if (ack) begin
        exp_q.push_back(tx_data[k]);
        exp_last = tx_data[k];
      end
      if (addressed && !tx_ready[k]) exp_ovr = 1'b1;
      send_bits(tx_data[k], 8);
      ack_slot(ack, addressed, {name, "_dack"});
    end
    rx_ready = 1'b1;
    i2c_stop();
    q();
    @(negedge clk);
    check({name, "_busy_after_stop"}, {31'd0, busy}, 32'd0);
    check({name, "_state_after_stop"}, {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check({name, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
    check({name, "_rx_data_hold"}, {24'd0, rx_data}, {24'd0, exp_last});
    check({name, "_scoreboard_drained"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    m_scl    = 1'b1;
    m_sda    = 1'b1;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    rx_ready = 1'b1;
    exp_ovr  = 1'b0;
    exp_last = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_sda_oe",   {31'd0, sda_oe},   32'd0);
    check("rst_rx_data",  {24'd0, rx_data},  32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_overrun",  {31'd0, overrun},  32'd0);
    check("rst_state",    {29'd0, dbg_state}, {29'd0, ST_IDLE});
    @(posedge clk);
    rst = 1'b0;
    q();

    // Addressed write of one byte.
    tx_data[0] = 8'hA5; tx_ready[0] = 1'b1;
    run_txn(7'h42, 1'b0, 1, "wr_a5");

    // Wrong address: no ACK anywhere, nothing delivered.
    tx_data[0] = 8'h55; tx_ready[0] = 1'b1;
    run_txn(7'h43, 1'b0, 1, "bad_addr");

    // Read to our address: NACKed and ignored.
    tx_data[0] = 8'hFF; tx_ready[0] = 1'b1;
    run_txn(7'h42, 1'b1, 1, "read");

    // Second byte refused by consumer.
    tx_data[0] = 8'h01; tx_ready[0] = 1'b1;
    tx_data[1] = 8'h02; tx_ready[1] = 1'b0;
    run_txn(7'h42, 1'b0, 2, "overrun");

    // Overrun is sticky across a clean transaction.
    tx_data[0] = 8'h11; tx_ready[0] = 1'b1;
    run_txn(7'h42, 1'b0, 1, "sticky");

    // Partial byte cut off by a repeated start.
    do_reset();
    q();
    i2c_start();
    send_bits({7'h42, 1'b0}, 8);
    ack_slot(1'b1, 1'b1, "rs_aack");
    send_bits(8'hF0, 4);
    tx_data[0] = 8'h3C; tx_ready[0] = 1'b1;
    run_txn(7'h42, 1'b0, 1, "rs_3c");

    // Reset mid-byte, then bus activity before a new start must be ignored.
    i2c_start();
    send_bits({7'h42, 1'b0}, 8);
    ack_slot(1'b1, 1'b1, "mr_aack");
    send_bits(8'hE8, 5);
    do_reset();
    @(negedge clk);
    check("mr_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("mr_rx_data", {24'd0, rx_data}, 32'd0);
    send_bits(8'hE8 << 5, 3);
    ack_slot(1'b0, 1'b0, "mr_tail");
    send_bits(8'h99, 8);
    ack_slot(1'b0, 1'b0, "mr_orphan");
    i2c_stop();
    tx_data[0] = 8'h77; tx_ready[0] = 1'b1;
    run_txn(7'h42, 1'b0, 1, "mr_77");

    // Simultaneous start and stop: stop wins.
    i2c_start();
    send_bits({7'h42, 1'b0}, 8);
    ack_slot(1'b1, 1'b1, "ss_aack");
    send_bits(8'hC0, 3);
    start_i = 1'b1;
    stop_i  = 1'b1;
    q();
    start_i = 1'b0;
    stop_i  = 1'b0;
    q();
    @(negedge clk);
    check("ss_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("ss_busy", {31'd0, busy}, 32'd0);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      logic [6:0] a;
      logic       rw;
      int         n;
      a  = ($urandom_range(0, 1) == 0) ? 7'h42 : 7'($urandom_range(0, 127));
      rw = ($urandom_range(0, 3) == 0);
      n  = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        tx_data[k]  = 8'($urandom_range(0, 255));
        tx_ready[k] = ($urandom_range(0, 4) != 0);
      end
      run_txn(a, rw, n, "rnd");
    end

    q();
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42: 7-bit slave address to match.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on all bus-side inputs, minimum 2.
REQ-003 clk  input  1  system clock; must run at least 8x the SCL frequency.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 scl_i  input  1  raw I2C SCL, asynchronous.
REQ-006 sda_i  input  1  raw I2C SDA, asynchronous.
REQ-007 start_i  input  1  Start level from the upstream start/stop detector, asynchronous.
REQ-008 stop_i  input  1  Stop level from the upstream start/stop detector, asynchronous.
REQ-009 sda_oe  output  1  1 = drive SDA low (ACK); 0 = release.
REQ-010 rx_data  output  8  last accepted data byte, MSB first on the wire.
REQ-011 rx_valid  output  1  one-clk pulse, rx_data newly valid.
REQ-012 rx_ready  input  1  consumer can accept a byte.
REQ-013 busy  output  1  addressed transaction in progress.
REQ-014 overrun  output  1  sticky; set when a byte is NACKed because rx_ready=0.

Function
REQ-015 scl_i, sda_i, start_i and stop_i SHALL each pass through SYNC_STAGES flops before any use.
REQ-016 SCL rise and fall events SHALL be single-clk pulses from the synchronized scl compared with its previous value.
REQ-017 A start SHALL be a synchronized start_i rising edge, and a stop a synchronized stop_i rising edge.
REQ-018 FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-019 IDLE: on start go to ADDR; clear the bit counter and shift register.
REQ-020 ADDR/DATA: on each SCL rise, shift synchronized sda into the LSB of an 8-bit shift register and increment a 3-bit counter.
REQ-021 ADDR/DATA: after the 8th bit, the next SCL fall SHALL leave the state.
REQ-022 Leaving ADDR:
  - if shift[7:1]==DEV_ADDR and shift[0]==0 (write): go to ADDR_ACK and assert sda_oe;
  - otherwise (mismatch or read): go to IGNORE with sda_oe=0.
REQ-023 ADDR_ACK: hold sda_oe=1 through the 9th SCL high.
REQ-024 ADDR_ACK: on the following SCL fall, release sda_oe, clear the counter and go to DATA.
REQ-025 Leaving DATA with rx_ready=1:
  - load rx_data from the shift register;
  - pulse rx_valid in the same clk as the SCL fall;
  - assert sda_oe and go to DATA_ACK.
REQ-026 Leaving DATA with rx_ready=0: set overrun, keep sda_oe=0, keep rx_data unchanged, go to DATA_ACK (NACK).
REQ-027 DATA_ACK: on the next SCL fall, release sda_oe, clear the counter and return to DATA.
REQ-028 IGNORE: sda_oe=0; wait for start or stop.
REQ-029 A start in any state SHALL force ADDR (repeated start), release sda_oe and clear the counter.
REQ-030 A stop in any state SHALL force IDLE and release sda_oe.
REQ-031 If start and stop are detected in the same clk, stop SHALL take priority.
REQ-032 busy SHALL be 1 in ADDR_ACK, DATA and DATA_ACK, and 0 in all other states.
REQ-033 overrun SHALL clear only on rst.
REQ-034 rx_valid SHALL never be high for two consecutive clks.

Reset
REQ-035 On rst: state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, busy=0, overrun=0, counter=0, all synchronizer flops=1 (idle bus).
REQ-036 rst asserted mid-transfer SHALL abort within the same clk edge, with no rx_valid pulse.
REQ-037 After rst is released, the block SHALL ignore bus activity until the next start.

Structure
REQ-038 The FSM state encoding and the I2C constants (address width 7, byte width 8) SHALL live in a shared package, i2c_pkg.
REQ-039 One sub-module, i2c_sync (a parameterized multi-stage synchronizer), SHALL be instantiated once per asynchronous input.
REQ-040 Target size: 120-400 RTL lines.

Verification
REQ-041 Start, addr 0x42+W, byte 0xA5, stop, rx_ready=1 -> sda_oe high during both 9th clocks; rx_data=0xA5; exactly one rx_valid pulse; busy low after stop.
REQ-042 Start, addr 0x43+W -> sda_oe never asserted; no rx_valid; busy=0 throughout.
REQ-043 Start, addr 0x42+R -> NACK on the address; state IGNORE; no rx_valid.
REQ-044 Start, 0x42+W, bytes 0x01 then 0x02 with rx_ready=0 during the second -> rx_data=0x01; sda_oe=0 on the second ACK slot; overrun=1.
REQ-045 Start, 0x42+W, 4 data bits, repeated start, 0x42+W, 0x3C -> rx_data=0x3C; the partial byte is discarded; one rx_valid.
REQ-046 rst pulsed after 5 data bits, then a full 0x42+W / 0x77 transfer -> no output before the new start; rx_data=0x77 afterwards.
